// File: rtl/noc_pkg.sv
// Shared types and widths for the NoC master arbiter.
package noc_pkg;
  localparam int FLIT_W    = 9;
  localparam int DEST_W    = 2;
  localparam int TLAST_BIT = FLIT_W - 1;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} arb_state_t;
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: the first set request found searching
// upward from ptr_i+1, wrapping modulo N.
module noc_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          vld_o,
  output logic [IW-1:0] win_o
);
  logic [IW-1:0] idx;

  // Walk candidates farthest-first so the nearest set request is written last.
  always_comb begin
    win_o = '0;
    idx   = '0;
    vld_o = |req_i;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_i + IW'(k) + IW'(1);
      if (req_i[idx]) win_o = idx;
    end
  end
endmodule

// File: rtl/noc_master_arbiter.sv
// NoC master arbiter: grants one processor at a time in round-robin order and
// forwards its flits to the router until tlast. Every output is registered.
// Optional burst timeout is compiled in with NOC_ARB_TIMEOUT_EN.
module noc_master_arbiter import noc_pkg::*; #(
  parameter int N_PROC    = 4,
  parameter int MAX_BURST = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_PROC-1:0]           req,
  input  logic [N_PROC*DEST_W-1:0]    dest,
  input  logic [N_PROC*FLIT_W-1:0]    flit_in,
  output logic [N_PROC-1:0]           master_response,
  output logic                        route_valid,
  output logic [$clog2(N_PROC)-1:0]   route_src,
  output logic [DEST_W-1:0]           route_dest,
  output flit_t                       route_flit,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int SW = $clog2(N_PROC);

  if ((N_PROC < 2) || ((N_PROC & (N_PROC - 1)) != 0) || (MAX_BURST < 1) || (MAX_BURST > 255))
  begin : g_bad_cfg
    $error("noc_master_arbiter: unsupported N_PROC/MAX_BURST");
  end

  // Per-processor views of the flattened buses.
  logic [N_PROC-1:0][FLIT_W-1:0] flit_a;
  logic [N_PROC-1:0][DEST_W-1:0] dest_a;
  assign flit_a = flit_in;
  assign dest_a = dest;

  arb_state_t          state_q, state_d;
  logic [SW-1:0]       src_q, src_d, rr_q, rr_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [N_PROC-1:0]   resp_q, resp_d;
  logic                vld_q, vld_d, busy_q, busy_d, tout_q, tout_d;
  flit_t               flit_q, flit_d;
`ifdef NOC_ARB_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
`endif

  logic                pick_vld;
  logic [SW-1:0]       pick_win;
  flit_t               cur_flit;

  noc_rr_pick #(.N(N_PROC)) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .vld_o (pick_vld),
    .win_o (pick_win)
  );

  assign cur_flit = flit_a[src_q];

  // Next-state and registered-output decode for the IDLE/GRANT/XFER sequence.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rr_d    = rr_q;
    dest_d  = dest_q;
    resp_d  = '0;
    vld_d   = 1'b0;
    flit_d  = flit_q;
    tout_d  = 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d          = GRANT;
        src_d            = pick_win;
        dest_d           = dest_a[pick_win];
        resp_d[pick_win] = 1'b1;
      end
      GRANT: begin
        state_d = XFER;
`ifdef NOC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      XFER: begin
        flit_d = cur_flit;
        vld_d  = 1'b1;
        if (cur_flit[TLAST_BIT]) begin
          rr_d    = src_q;
          state_d = IDLE;
        end
`ifdef NOC_ARB_TIMEOUT_EN
        // Abort on the MAX_BURST-th XFER cycle with no tlast; the flit is dropped.
        else if (cnt_q == 8'(MAX_BURST - 1)) begin
          vld_d   = 1'b0;
          tout_d  = 1'b1;
          rr_d    = src_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset gives processor 0 first priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      rr_q    <= SW'(N_PROC - 1);
      dest_q  <= '0;
      resp_q  <= '0;
      vld_q   <= 1'b0;
      flit_q  <= '0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      dest_q  <= dest_d;
      resp_q  <= resp_d;
      vld_q   <= vld_d;
      flit_q  <= flit_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
`ifdef NOC_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign master_response = resp_q;
  assign route_valid     = vld_q;
  assign route_src       = src_q;
  assign route_dest      = dest_q;
  assign route_flit      = flit_q;
  assign busy            = busy_q;
  assign timeout_err     = tout_q;
endmodule
